// File: rtl/capture_bank_scheduler_pkg.sv
// Shared constants and FSM encoding for the capture bank scheduler.
package capture_bank_scheduler_pkg;

  localparam int unsigned CH   = 8;
  localparam int unsigned SELW = 3;

  typedef enum logic {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } state_e;

endpackage

// File: rtl/capture_bank_scheduler_rr_pick8.sv
// Combinational rotating-priority encoder: first set bit of pending_i scanning
// from ptr_i upward with wrap from 7 to 0.
module rr_pick8
  import capture_bank_scheduler_pkg::*;
(
  input  logic [CH-1:0]   pending_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] grant_o,
  output logic            any_o
);

  logic [SELW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    any_o   = |pending_i;
    for (int i = CH - 1; i >= 0; i--) begin
      idx = ptr_i + SELW'(i);
      if (pending_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/capture_bank_scheduler.sv
// Eight per-channel capture registers feeding an 8:1 mux, served round-robin
// to a downstream valid/ready consumer.
module capture_bank_scheduler
  import capture_bank_scheduler_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CH-1:0]   ld_i,
  input  logic [N-1:0]    din0_i,
  input  logic [N-1:0]    din1_i,
  input  logic [N-1:0]    din2_i,
  input  logic [N-1:0]    din3_i,
  input  logic [N-1:0]    din4_i,
  input  logic [N-1:0]    din5_i,
  input  logic [N-1:0]    din6_i,
  input  logic [N-1:0]    din7_i,
  input  logic            ovf_clr_i,
  output logic [N-1:0]    q0_o,
  output logic [N-1:0]    q1_o,
  output logic [N-1:0]    q2_o,
  output logic [N-1:0]    q3_o,
  output logic [N-1:0]    q4_o,
  output logic [N-1:0]    q5_o,
  output logic [N-1:0]    q6_o,
  output logic [N-1:0]    q7_o,
  output logic [SELW-1:0] sel_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [CH-1:0]   pending_o,
  output logic [CH-1:0]   overflow_o
);

  logic [CH-1:0][N-1:0] q_q, q_d, din;
  logic [CH-1:0]        pending_q, pending_d;
  logic [CH-1:0]        overflow_q, overflow_d, ovf_set;
  logic [SELW-1:0]      sel_q, sel_d, ptr_q, ptr_d, grant;
  logic                 out_valid_q, out_valid_d, any, hs;
  state_e               state_q, state_d;

  assign din = {din7_i, din6_i, din5_i, din4_i, din3_i, din2_i, din1_i, din0_i};
  assign hs  = out_valid_q & out_ready_i;

  rr_pick8 u_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .any_o     (any)
  );

  // A load is accepted into an empty slot, or into the slot being consumed this
  // edge (refill); anything else is dropped and flagged.
  always_comb begin
    q_d       = q_q;
    pending_d = pending_q;
    ovf_set   = '0;
    if (hs) begin
      pending_d[sel_q] = 1'b0;
    end
    for (int k = 0; k < CH; k++) begin
      if (ld_i[k]) begin
        if (!pending_q[k] || (hs && (sel_q == SELW'(k)))) begin
          q_d[k]       = din[k];
          pending_d[k] = 1'b1;
        end else begin
          ovf_set[k] = 1'b1;
        end
      end
    end
    overflow_d = (ovf_clr_i ? '0 : overflow_q) | ovf_set;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          sel_d       = grant;
          out_valid_d = 1'b1;
          state_d     = StPresent;
        end
      end
      StPresent: begin
        if (hs) begin
          ptr_d       = sel_q + SELW'(1);
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q         <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= StIdle;
    end else begin
      q_q         <= q_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  assign q0_o        = q_q[0];
  assign q1_o        = q_q[1];
  assign q2_o        = q_q[2];
  assign q3_o        = q_q[3];
  assign q4_o        = q_q[4];
  assign q5_o        = q_q[5];
  assign q6_o        = q_q[6];
  assign q7_o        = q_q[7];
  assign sel_o       = sel_q;
  assign out_valid_o = out_valid_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;

endmodule
